// File: rtl/instr_fetch.sv
// Fetch stage of the RV32 multicycle core: owns the PC, issues one instruction-memory
// read at a time, and holds the returned word for the decoder with redirect support.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        misalign_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        capture_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] instr_pc_r;
    logic        req_valid_r;
    logic        instr_valid_r;
    logic        misalign_r;

    // Next-state decode; a redirect overrides every other event in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                state_nxt_s = REQ;
            end
            REQ: begin
                if (imem_req_ready) begin
                    state_nxt_s = redirect_valid ? DRAIN : WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid) begin
                        state_nxt_s = REQ;
                    end else begin
                        state_nxt_s = HOLD;
                        capture_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = redirect_valid ? DRAIN : WAIT;
                end
            end
            HOLD: begin
                if (redirect_valid || instr_ready) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, PC, instruction register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            instr_r       <= 32'h0000_0000;
            instr_pc_r    <= 32'h0000_0000;
            req_valid_r   <= 1'b0;
            instr_valid_r <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            req_valid_r   <= (state_nxt_s == REQ);
            instr_valid_r <= (state_nxt_s == HOLD);
            misalign_r    <= redirect_valid & (|redirect_pc[1:0]);
            if (redirect_valid) begin
                pc_r <= {redirect_pc[31:2], 2'b00};
            end else if (capture_s) begin
                pc_r <= pc_r + 32'd4;
            end else begin
                pc_r <= pc_r;
            end
            if (capture_s) begin
                instr_r    <= imem_rsp_data;
                instr_pc_r <= pc_r;
            end else begin
                instr_r    <= instr_r;
                instr_pc_r <= instr_pc_r;
            end
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;
    assign instr_valid    = instr_valid_r;
    assign instr          = instr_r;
    assign instr_pc       = instr_pc_r;
    assign instr_pc_plus4 = instr_pc_r + 32'd4;
    assign misalign_err   = misalign_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a reset-PC-0 instance and a wrap-around instance share
// every input; a small memory model answers the first instance's requests.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic        imem_req_valid, instr_valid, misalign_err;
    logic [31:0] imem_req_addr, instr, instr_pc, instr_pc_plus4;
    logic        w_req_valid, w_instr_valid, w_misalign_err;
    logic [31:0] w_req_addr, w_instr, w_instr_pc, w_instr_pc_plus4;

    int errors = 0;
    int checks = 0;
    int lat = 1;
    int cnt = 0;
    logic [31:0] paddr = 32'h0000_0000;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
        .misalign_err(misalign_err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_valid(w_instr_valid), .instr_ready(instr_ready),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_pc_plus4(w_instr_pc_plus4),
        .misalign_err(w_misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: response appears lat cycles after the accepting edge, for one cycle.
    always @(posedge clk) begin
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid & imem_req_ready;
        a   = imem_req_addr;
        #1;
        imem_rsp_valid = 1'b0;
        if (acc) begin
            paddr = a;
            cnt   = lat;
        end
        if (cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(paddr);
            cnt = 0;
        end else if (cnt > 1) begin
            cnt = cnt - 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
        step(); step();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
        checks++; if (w_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_wrap: got %h want fffffffc", w_req_addr); end
        rst_n = 1'b1;
        step();
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_to_req: got %b want 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_first_addr: got %h want 0", imem_req_addr); end
    endtask

    task automatic test_fetch();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            a = 32'(k * 4);
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin errors++; $display("FAIL fetch_req: got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, a); end
            step();
            checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL fetch_wait: got rv=%b iv=%b want 0 0", imem_req_valid, instr_valid); end
            step();
            checks++; if (instr_valid !== 1'b1 || instr_pc !== a) begin errors++; $display("FAIL fetch_hold_pc: got v=%b pc=%h want v=1 pc=%h", instr_valid, instr_pc, a); end
            checks++; if (instr !== mem_word(a)) begin errors++; $display("FAIL fetch_instr: got %h want %h", instr, mem_word(a)); end
            checks++; if (instr_pc_plus4 !== a + 32'd4) begin errors++; $display("FAIL fetch_plus4: got %h want %h", instr_pc_plus4, a + 32'd4); end
            step();
        end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        checks++; if (imem_req_addr !== 32'h0000_000C) begin errors++; $display("FAIL stall_req_addr: got %h want c", imem_req_addr); end
        step(); step();
        for (int k = 0; k < 5; k++) begin
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_000C || instr !== mem_word(32'h0000_000C)) begin errors++; $display("FAIL stall_hold: got v=%b pc=%h i=%h want v=1 pc=c i=%h", instr_valid, instr_pc, instr, mem_word(32'h0000_000C)); end
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_no_req: got %b want 0", imem_req_valid); end
            step();
        end
        instr_ready = 1'b1;
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0010 || instr_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got rv=%b a=%h iv=%b want 1 10 0", imem_req_valid, imem_req_addr, instr_valid); end
    endtask

    task automatic test_redirect_wait();
        lat = 2;
        step();
        checks++; if (imem_req_valid !== 1'b0 || imem_rsp_valid !== 1'b0) begin errors++; $display("FAIL rdw_in_wait: got rv=%b rsp=%b want 0 0", imem_req_valid, imem_rsp_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL rdw_drain: got rv=%b iv=%b me=%b want 0 0 0", imem_req_valid, instr_valid, misalign_err); end
        step();
        lat = 1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100) begin errors++; $display("FAIL rdw_new_req: got v=%b a=%h want 1 100", imem_req_valid, imem_req_addr); end
        checks++; if (instr_pc !== 32'h0000_000C || instr_valid !== 1'b0) begin errors++; $display("FAIL rdw_stale_dropped: got pc=%h v=%b want c 0", instr_pc, instr_valid); end
        step(); step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_0100 || instr !== mem_word(32'h0000_0100)) begin errors++; $display("FAIL rdw_deliver: got v=%b pc=%h i=%h want 1 100 %h", instr_valid, instr_pc, instr, mem_word(32'h0000_0100)); end
    endtask

    task automatic test_redirect_hold();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; instr_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL rdh_misalign_on: got %b want 1", misalign_err); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0200 || instr_valid !== 1'b0) begin errors++; $display("FAIL rdh_req: got rv=%b a=%h iv=%b want 1 200 0", imem_req_valid, imem_req_addr, instr_valid); end
        step();
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rdh_misalign_off: got %b want 0", misalign_err); end
        step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_0200 || instr !== mem_word(32'h0000_0200)) begin errors++; $display("FAIL rdh_deliver: got v=%b pc=%h i=%h want 1 200 %h", instr_valid, instr_pc, instr, mem_word(32'h0000_0200)); end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first_req: got v=%b a=%h want 1 fffffffc", w_req_valid, w_req_addr); end
        step(); step();
        checks++; if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr_pc: got v=%b pc=%h want 1 fffffffc", w_instr_valid, w_instr_pc); end
        checks++; if (w_instr_pc_plus4 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_plus4: got %h want 0", w_instr_pc_plus4); end
        step();
        checks++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next_req: got v=%b a=%h want 1 0", w_req_valid, w_req_addr); end
    endtask

    task automatic test_reset_mid();
        step();
        checks++; if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rstm_setup: got rsp=%b rv=%b want 1 0", imem_rsp_valid, imem_req_valid); end
        rst_n = 1'b0;
        step();
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL rstm_in_reset: got rv=%b iv=%b i=%h pc=%h want 0 0 0 0", imem_req_valid, instr_valid, instr, instr_pc); end
        rst_n = 1'b1;
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rstm_release: got rv=%b a=%h iv=%b want 1 0 0", imem_req_valid, imem_req_addr, instr_valid); end
    endtask

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
